// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared types and defaults for the word scanner and its bit matcher
package seqdet_pkg;

  // Scanner sequencing states; encodings fixed for compatibility with existing dumps
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam int                   DEF_PAT_W   = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1101;

  localparam int REC_CNT_W = 5;
  localparam int REC_POS_W = 4;

  // Result record layout for the default configuration
  typedef struct packed {
    logic [REC_CNT_W-1:0] count;
    logic                 hit;
    logic [REC_POS_W-1:0] first_pos;
  } result_t;

endpackage

// File: rtl/seqdet_core.sv
// rtl/seqdet_core.sv - overlapping Mealy matcher whose prefix automaton is derived from PATTERN
module seqdet_core
  import seqdet_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_valid,
  input  logic din,
  output logic match
);

  // State is the length of the longest proper prefix of PATTERN that ends the history
  localparam int SW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic [SW-1:0] len_q, len_d;
  logic          full_hit;

  // Bit i of PATTERN counted from the LSB
  function automatic logic pat_bit(input int i);
    logic [PAT_W-1:0] t;
    t = PATTERN >> i;
    return t[0];
  endfunction

  // True when the last k bits of (prefix of length len, then b) equal the first k pattern bits
  function automatic logic border_ok(input int len, input logic b, input int k);
    logic ok;
    int   pos;
    logic wb;
    ok = 1'b1;
    for (int j = 0; j < PAT_W; j++) begin
      if (j < k) begin
        pos = len + 1 - k + j;
        wb  = (pos == len) ? b : pat_bit(PAT_W - 1 - pos);
        if (wb != pat_bit(PAT_W - 1 - j)) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Next prefix length is the longest border below PAT_W; a full-length border is a match
  always_comb begin
    len_d    = '0;
    full_hit = 1'b0;
    for (int k = 1; k <= PAT_W; k++) begin
      if ((k <= int'(len_q) + 1) && border_ok(int'(len_q), din, k)) begin
        if (k == PAT_W) full_hit = 1'b1;
        else            len_d    = SW'(k);
      end
    end
  end

  // History advances only on valid bits; clear wins over a valid bit
  always_ff @(posedge clk) begin
    if (rst || clear) len_q <= '0;
    else if (bit_valid) len_q <= len_d;
  end

  assign match = bit_valid && !clear && full_hit;

endmodule

// File: rtl/seqdet_word_scanner.sv
// rtl/seqdet_word_scanner.sv - word-to-bit sequencer and match accounting; SEQDET_CARRY_EN keeps matcher history across words
module seqdet_word_scanner
  import seqdet_pkg::*;
#(
  parameter int               WORD_W  = 16,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               CNT_W   = 5,
  parameter int               POS_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_hit,
  output logic [POS_W-1:0]  out_first_pos
);

  localparam logic [POS_W-1:0] LAST_BIT = POS_W'(WORD_W - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [POS_W-1:0]  bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              hit_q, hit_d;
  logic [POS_W-1:0]  first_pos_q, first_pos_d;

  logic core_clear;
  logic core_valid;
  logic core_match;

  seqdet_core #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (core_clear),
    .bit_valid(core_valid),
    .din      (shreg_q[WORD_W-1]),
    .match    (core_match)
  );

  // Sequencing: accept a word, feed it MSB-first, then hold the record until taken
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    count_d     = count_q;
    hit_d       = hit_q;
    first_pos_d = first_pos_q;
    core_clear  = 1'b0;
    core_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d     = in_word;
          bitcnt_d    = '0;
          count_d     = '0;
          hit_d       = 1'b0;
          first_pos_d = '0;
          state_d     = ST_SHIFT;
`ifdef SEQDET_CARRY_EN
          core_clear  = 1'b0;
`else
          core_clear  = 1'b1;
`endif
        end
      end
      ST_SHIFT: begin
        core_valid = 1'b1;
        shreg_d    = shreg_q << 1;
        bitcnt_d   = bitcnt_q + POS_W'(1);
        if (core_match) begin
          if (count_q != '1) count_d = count_q + CNT_W'(1);
          if (!hit_q) begin
            hit_d       = 1'b1;
            first_pos_d = bitcnt_q;
          end
        end
        if (bitcnt_q == LAST_BIT) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset discards any word in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      count_q     <= '0;
      hit_q       <= 1'b0;
      first_pos_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      count_q     <= count_d;
      hit_q       <= hit_d;
      first_pos_q <= first_pos_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = (state_q == ST_REPORT);
  assign out_count     = count_q;
  assign out_hit       = hit_q;
  assign out_first_pos = first_pos_q;

endmodule

// File: tb/tb_seqdet_word_scanner.sv
// tb/tb_seqdet_word_scanner.sv - directed and randomized checks of the word scanner against a bit-history model
module tb_seqdet_word_scanner;

  localparam int         W     = 16;
  localparam int         PW    = 4;
  localparam logic [3:0] PAT   = 4'b1101;
  localparam int         CMAX  = 31;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_count;
  logic        out_hit;
  logic [3:0]  out_first_pos;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  seqdet_word_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_word      (in_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_count    (out_count),
    .out_hit      (out_hit),
    .out_first_pos(out_first_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 scanning, 2 reporting
  int m_phase = 0;
  int m_left  = 0;
  bit m_hist[$];
  int e_cnt = 0;
  int e_hit = 0;
  int e_pos = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_hist.delete();
      e_cnt = 0; e_hit = 0; e_pos = 0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
`ifndef SEQDET_CARRY_EN
        m_hist.delete();
`endif
        e_cnt = 0; e_hit = 0; e_pos = 0;
        for (int i = 0; i < W; i++) begin
          bit same;
          m_hist.push_back(in_word[W-1-i]);
          if (m_hist.size() > PW) void'(m_hist.pop_front());
          same = (m_hist.size() == PW);
          for (int j = 0; j < PW; j++)
            if (same && m_hist[j] != PAT[PW-1-j]) same = 1'b0;
          if (same) begin
            if (e_cnt < CMAX) e_cnt++;
            if (e_hit == 0) begin e_hit = 1; e_pos = i; end
          end
        end
        m_phase = 1;
        m_left  = W;
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) m_phase = 2;
    end else if (out_ready) begin
      m_phase = 0;
    end
  end

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", int'(in_ready), int'(m_phase == 0));
      chk("cyc_out_valid", int'(out_valid), int'(m_phase == 2));
      if (m_phase == 2) begin
        chk("cyc_count", int'(out_count), e_cnt);
        chk("cyc_hit", int'(out_hit), e_hit);
        chk("cyc_pos", int'(out_first_pos), e_pos);
      end
    end
  end

  task automatic wait_valid(input string nm, output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_word(input logic [15:0] w, input int ecnt, input int ehit,
                          input int epos, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, "_ready_pre"}, int'(in_ready), 1);
    in_valid = 1'b1; in_word = w; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(nm, lat);
    chk({nm, "_latency"}, lat, 17);
    chk({nm, "_count"}, int'(out_count), ecnt);
    chk({nm, "_hit"}, int'(out_hit), ehit);
    chk({nm, "_pos"}, int'(out_first_pos), epos);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_ready_post"}, int'(in_ready), 1);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_count", int'(out_count), 0);
    chk("rst_hit", int'(out_hit), 0);
    chk("rst_pos", int'(out_first_pos), 0);
    chk_en = 1'b1;

    run_word(16'hD000, 1, 1, 3, "d000");
    run_word(16'hDB6D, 5, 1, 3, "db6d");
    run_word(16'h0000, 0, 0, 0, "zero");
    run_word(16'hFFFF, 0, 0, 0, "ones");
    run_word(16'h0006, 0, 0, 0, "w0006");
`ifdef SEQDET_CARRY_EN
    run_word(16'h8000, 1, 1, 0, "w8000_carry");
`else
    run_word(16'h8000, 0, 0, 0, "w8000_nocarry");
`endif

    // Back-pressure: record held, new word refused until released
    @(negedge clk);
    in_valid = 1'b1; in_word = 16'hD000; out_ready = 1'b0;
    @(negedge clk);
    in_word = 16'h000D;
    wait_valid("bp", lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_count", int'(out_count), 1);
      chk("bp_pos", int'(out_first_pos), 3);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_accepted", int'(in_ready), 0);
    wait_valid("bp2", lat);
    chk("bp2_count", int'(out_count), 1);
    chk("bp2_pos", int'(out_first_pos), 15);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while bit 7 of DB6D is being scanned
    in_valid = 1'b1; in_word = 16'hDB6D;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    run_word(16'h000D, 1, 1, 15, "after_rst");

    // Randomized traffic with random back-pressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 399) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_word   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) in_word = in_word | 16'hD00D;
      out_ready = ($urandom_range(0, 2) != 0);
    end

    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("drain_in_ready", int'(in_ready), 1);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
